// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the unified memory arbiter and the memory macro.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [1:0]        gnt;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, gnt
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, gnt
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the load/store unit.
// One transaction at a time (IDLE -> BUSY -> RESP), data-first with bounded fetch starvation.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  unified_mem_arbiter_if.master bus
);

  localparam int unsigned    CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_starve_cnt;
  logic              r_owner_dm;
  logic [1:0]        r_gnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;

  logic w_any_req;
  logic w_starved;
  logic w_grant_dm;

  // Data wins a tie unless fetch has already waited out STARVE_LIMIT data grants.
  always_comb begin
    w_any_req  = bus.if_req | bus.dm_req;
    w_starved  = (r_starve_cnt == CntMax);
    w_grant_dm = bus.dm_req & ~(bus.if_req & w_starved);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_owner_dm   <= 1'b0;
      r_gnt        <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state    <= StBusy;
            r_mem_req  <= 1'b1;
            r_owner_dm <= w_grant_dm;
            if (w_grant_dm) begin
              r_gnt       <= 2'b10;
              r_mem_we    <= bus.dm_we;
              r_mem_addr  <= bus.dm_addr;
              r_mem_wdata <= bus.dm_wdata;
              if (bus.if_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              r_gnt        <= 2'b01;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= bus.if_addr;
              r_starve_cnt <= '0;
            end
          end
        end
        StBusy: begin
          if (bus.mem_ready) begin
            r_state   <= StResp;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_gnt     <= 2'b00;
            if (r_owner_dm) begin
              r_dm_ack <= 1'b1;
              if (!r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
              end
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.gnt       = r_gnt;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single-port unified instruction/data memory between the pipeline's instruction-fetch stage and its MEM-stage load/store unit. Requests are handled one at a time through a three-state FSM with registered memory-side signals, and a bounded-starvation priority scheme. Sits between `Program_Counter`/`if_id` (fetch side), the `ex_mem` stage (data side) and the shared memory macro. The hazard logic stalls a stage while its request is pending.

## Interface
- `ADDR_W`, 32, address width for all ports.
- `DATA_W`, 32, data width for all ports.
- `STARVE_LIMIT`, 4, consecutive data grants allowed while a fetch waits; legal range ≥1.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; registered, valid while `if_ack`=1 and held until the next fetch completes.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `dm_req`  in  1  data request; held with `dm_we`/`dm_addr`/`dm_wdata` stable until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_rdata`  out  DATA_W  load data; registered, updated only by loads.
- `dm_ack`  out  1  one-cycle completion pulse for data.
- `mem_req`  out  1  memory access request; registered.
- `mem_we`  out  1  memory write enable; registered, 0 for fetches.
- `mem_addr`  out  ADDR_W  latched address of granted request.
- `mem_wdata`  out  DATA_W  latched store data; don't-care on reads.
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completion; sampled only in BUSY.
- `gnt`  out  2  current owner: 2'b00 none, 2'b01 fetch, 2'b10 data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: no request → stay. Otherwise grant per arbitration, latch `mem_addr`/`mem_we`/`mem_wdata` from winner, set `gnt`, assert `mem_req`, go BUSY.
- Arbitration in IDLE:
  - Only one request → that requester wins.
  - Both requests → data wins unless `starve_cnt` == STARVE_LIMIT, in which case fetch wins.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)):
  - Increments (saturating at STARVE_LIMIT) when data is granted while `if_req`=1.
  - Clears to 0 whenever fetch is granted.
  - Otherwise holds.
- BUSY: hold all `mem_*` outputs stable. On `mem_ready`=1:
  - Drop `mem_req`/`mem_we`.
  - If owner is fetch, capture `mem_rdata` into `if_rdata`.
  - If owner is data and the access is a load, capture `mem_rdata` into `dm_rdata`; on a store, `dm_rdata` is unchanged.
  - Go RESP.
- RESP: pulse the owner's ack for exactly one cycle, clear `gnt`, go IDLE. Requester may drop or change its request at the edge ending the ack cycle; IDLE evaluates the new value.
- `mem_ready` outside BUSY is ignored.
- Request inputs changing while BUSY do not affect the latched transaction (protocol violation, no checking).
- `if_ack` and `dm_ack` are never high together; `gnt` is nonzero only in BUSY.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE, `starve_cnt` 0, `gnt` 00.
  - `mem_req`, `mem_we`, `if_ack`, `dm_ack` 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` 0.
- Reset mid-transaction: the in-flight access is abandoned and no ack is issued. The memory must tolerate `mem_req` dropping.
- Latency, `req` high in IDLE at cycle 0:
  - `mem_req` high from cycle 1.
  - With `mem_ready` in cycle 1+k, ack in cycle 2+k.
  - Minimum latency is 2 cycles; minimum issue interval is 3 cycles per transfer.
- Back-to-back: the request following an ack is granted in the cycle after the ack cycle.
- Starvation bound, both requesters continuously active: at most STARVE_LIMIT data transfers complete between fetch grants.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x0000_0010, memory returns 0x0000_0093 with `mem_ready` in cycle 1 → `mem_req` cycle 1 with `mem_we`=0, `mem_addr`=0x10; `if_ack` pulse cycle 2; `if_rdata`=0x93; `gnt`=01 only in cycle 1.
- Store then load: store 0xDEADBEEF at 0x100 with 3-cycle memory wait → `mem_we`=1 and `mem_wdata`=0xDEADBEEF held 3 cycles, `dm_ack` 1 cycle later, `dm_rdata` unchanged. Then a load from 0x100 returns 0xDEADBEEF in `dm_rdata` with `dm_ack`.
- Contention, STARVE_LIMIT=4, both requests held continuously, zero-wait memory → grant order D,D,D,D,F,D,D,D,D,F…; `starve_cnt` reads 4 at each fetch grant and 0 after it.
- Simultaneous arrival with `starve_cnt`=0 → data is granted first; fetch is granted in the IDLE cycle immediately after `dm_ack`.
- Reset mid-BUSY: deassert `rst_n` while waiting on `mem_ready` → `mem_req`, `gnt` and both acks go 0 immediately; no ack after release; the next request starts cleanly from IDLE.
- Spurious `mem_ready`=1 held in IDLE with no requests → no state change, no ack, outputs unchanged.
